// File: rtl/cpu_run_ctrl.sv
// Run controller: hands the single-port data memory to the host or the CPU and sequences
// start / halt / timeout / abort for each run. Status is registered; ownership mux is combinational.
module cpu_run_ctrl #(
   parameter int AW         = 8,
   parameter int DW         = 8,
   parameter int CNT_W      = 16,
   parameter int MAX_CYCLES = 4096
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic             abort,
   input  logic             host_req,
   input  logic             host_we,
   input  logic [AW-1:0]    host_addr,
   input  logic [DW-1:0]    host_wdata,
   output logic             host_gnt,
   output logic [DW-1:0]    host_rdata,
   output logic             cpu_start,
   input  logic             cpu_halt,
   input  logic             cpu_mem_we,
   input  logic [AW-1:0]    cpu_mem_addr,
   input  logic [DW-1:0]    cpu_mem_wdata,
   output logic [DW-1:0]    cpu_mem_rdata,
   output logic             mem_we,
   output logic [AW-1:0]    mem_addr,
   output logic [DW-1:0]    mem_wdata,
   input  logic [DW-1:0]    mem_rdata,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_RUN,
      S_DONE,
      S_TIMEOUT
   } state_t;

   // Count seen during the last allowed RUN cycle (count lags the cycle index by one).
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_q, state_d;
   logic             done_q, done_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      done_d    = done_q;
      timeout_d = timeout_q;
      cnt_d     = cnt_q;
      case (state_q)
         S_IDLE, S_DONE, S_TIMEOUT: begin
            if (go) begin
               state_d   = S_START;
               done_d    = 1'b0;
               timeout_d = 1'b0;
               cnt_d     = '0;
            end
         end
         // A halt level left over from the previous run must not end this one here.
         S_START: state_d = S_RUN;
         S_RUN: begin
            cnt_d = cnt_q + CNT_ONE;
            if (cpu_halt) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else if (cnt_q == LAST_CNT) begin
               state_d   = S_TIMEOUT;
               timeout_d = 1'b1;
            end else if (abort) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   logic host_own;

   always_comb begin
      busy      = (state_q == S_START) || (state_q == S_RUN);
      cpu_start = (state_q == S_START);
      host_own  = !busy;
      host_gnt  = host_own && host_req;
      if (host_own) begin
         mem_we    = host_req && host_we;
         mem_addr  = host_addr;
         mem_wdata = host_wdata;
      end else begin
         // The CPU only sees the start pulse in START, so its write port is held off there.
         mem_we    = (state_q == S_RUN) && cpu_mem_we;
         mem_addr  = cpu_mem_addr;
         mem_wdata = cpu_mem_wdata;
      end
   end

   assign host_rdata    = mem_rdata;
   assign cpu_mem_rdata = mem_rdata;
   assign done          = done_q;
   assign timeout       = timeout_q;
   assign cycle_count   = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a behavioural data memory and a scripted CPU.
module tb_cpu_run_ctrl;
   localparam int AW = 8, DW = 8, CNT_W = 16, MAXC = 16;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic go = 1'b0, abort = 1'b0;
   logic host_req = 1'b0, host_we = 1'b0;
   logic [AW-1:0] host_addr = '0;
   logic [DW-1:0] host_wdata = '0;
   logic host_gnt;
   logic [DW-1:0] host_rdata;
   logic cpu_start;
   logic cpu_halt = 1'b0;
   logic cpu_mem_we = 1'b0;
   logic [AW-1:0] cpu_mem_addr = '0;
   logic [DW-1:0] cpu_mem_wdata = '0;
   logic [DW-1:0] cpu_mem_rdata;
   logic mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic busy, done, timeout;
   logic [CNT_W-1:0] cycle_count;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] mem [256];

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
   assign mem_rdata = mem[mem_addr];

   cpu_run_ctrl #(.AW(AW), .DW(DW), .CNT_W(CNT_W), .MAX_CYCLES(MAXC)) dut (
      .clk(clk), .reset(reset), .go(go), .abort(abort),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_rdata(host_rdata),
      .cpu_start(cpu_start), .cpu_halt(cpu_halt),
      .cpu_mem_we(cpu_mem_we), .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
      .cpu_mem_rdata(cpu_mem_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   // Host write that must be granted; leaves the bus idle at the next negedge.
   task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
      #1;
      checks++;
      if (host_gnt !== 1'b1) begin errors++; $display("FAIL host_write_gnt @%0h: got %b want 1", a, host_gnt); end
      tick();
      host_req = 1'b0; host_we = 1'b0;
   endtask

   task automatic host_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
      host_req = 1'b1; host_we = 1'b0; host_addr = a;
      #1;
      checks++;
      if (host_gnt !== 1'b1 || host_rdata !== exp) begin
         errors++; $display("FAIL host_read @%0h: gnt=%b data=%h want gnt=1 data=%h", a, host_gnt, host_rdata, exp);
      end
      tick();
      host_req = 1'b0;
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      host_req = 1'b1;
      #2;
      checks++;
      if ({busy, cpu_start, done, timeout} !== 4'b0000 || cycle_count !== 16'd0) begin
         errors++; $display("FAIL reset_state: busy=%b start=%b done=%b to=%b cnt=%0d want all 0", busy, cpu_start, done, timeout, cycle_count);
      end
      checks++;
      if (host_gnt !== 1'b1) begin errors++; $display("FAIL reset_gnt: got %b want 1", host_gnt); end
      tick();
      reset = 1'b0; host_req = 1'b0;
      tick();
   endtask

   task automatic test_load_run();
      logic [DW-1:0] d0, d1;
      d0 = '0; d1 = '0;
      host_write(8'd0, 8'h34);
      host_write(8'd1, 8'h12);
      go = 1'b1;
      tick();
      go = 1'b0;
      // START: host hammers addr 0, CPU tries an early write that must be blocked.
      host_req = 1'b1; host_we = 1'b1; host_addr = 8'd0; host_wdata = 8'hFF;
      cpu_mem_we = 1'b1; cpu_mem_addr = 8'd9; cpu_mem_wdata = 8'h00;
      #1;
      checks++;
      if (cpu_start !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL start_pulse: start=%b busy=%b want 1 1", cpu_start, busy); end
      checks++;
      if (host_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 8'd9) begin
         errors++; $display("FAIL start_mux: gnt=%b we=%b addr=%0h want 0 0 9", host_gnt, mem_we, mem_addr);
      end
      tick();
      for (int k = 1; k <= 10; k++) begin
         cpu_mem_we = 1'b0; cpu_mem_addr = 8'd0;
         case (k)
            2: begin cpu_mem_we = 1'b1; cpu_mem_addr = 8'd2; cpu_mem_wdata = d0; end
            3: cpu_mem_addr = 8'd1;
            4: begin cpu_mem_we = 1'b1; cpu_mem_addr = 8'd3; cpu_mem_wdata = d1; end
            default: ;
         endcase
         cpu_halt = (k == 10);
         #1;
         if (k == 1) d0 = cpu_mem_rdata;
         if (k == 3) d1 = cpu_mem_rdata;
         checks++;
         if (host_gnt !== 1'b0 || mem_we !== cpu_mem_we || busy !== 1'b1 || cpu_start !== 1'b0) begin
            errors++; $display("FAIL run_mux k=%0d: gnt=%b we=%b busy=%b start=%b want 0 %b 1 0", k, host_gnt, mem_we, busy, cpu_start, cpu_mem_we);
         end
         tick();
      end
      checks++;
      if (d0 !== 8'h34 || d1 !== 8'h12) begin errors++; $display("FAIL cpu_read: got %h %h want 34 12", d0, d1); end
      host_we = 1'b0; cpu_halt = 1'b0; cpu_mem_we = 1'b0;
      #1;
      checks++;
      if (done !== 1'b1 || timeout !== 1'b0 || cycle_count !== 16'd10 || busy !== 1'b0) begin
         errors++; $display("FAIL run_done: done=%b to=%b cnt=%0d busy=%b want 1 0 10 0", done, timeout, cycle_count, busy);
      end
      host_read(8'd2, 8'h34);
      host_read(8'd3, 8'h12);
      host_read(8'd0, 8'h34);
   endtask

   task automatic test_timeout();
      go = 1'b1;
      tick();
      go = 1'b0;
      #1;
      checks++;
      if (done !== 1'b0 || cycle_count !== 16'd0) begin errors++; $display("FAIL go_clear: done=%b cnt=%0d want 0 0", done, cycle_count); end
      for (int j = 1; j <= 18; j++) begin
         if (j > 1) #1;
         checks++;
         if (busy !== (j <= 17)) begin errors++; $display("FAIL timeout_busy j=%0d: got %b want %b", j, busy, (j <= 17)); end
         if (j < 18) tick();
      end
      checks++;
      if (timeout !== 1'b1 || done !== 1'b0 || cycle_count !== 16'd16) begin
         errors++; $display("FAIL timeout_end: to=%b done=%b cnt=%0d want 1 0 16", timeout, done, cycle_count);
      end
      tick();
   endtask

   task automatic test_final_halt();
      go = 1'b1;
      tick();
      go = 1'b0;
      for (int j = 1; j <= 17; j++) begin
         cpu_halt = (j == 17);
         tick();
      end
      cpu_halt = 1'b0;
      #1;
      checks++;
      if (done !== 1'b1 || timeout !== 1'b0 || cycle_count !== 16'd16) begin
         errors++; $display("FAIL final_halt: done=%b to=%b cnt=%0d want 1 0 16", done, timeout, cycle_count);
      end
      tick();
   endtask

   task automatic test_abort_stale_halt();
      int pulses;
      go = 1'b1;
      tick();
      go = 1'b0;
      abort = 1'b1;              // in START: must be ignored
      tick();
      abort = 1'b0;
      for (int j = 2; j <= 6; j++) begin
         abort = (j == 6);
         tick();
      end
      abort = 1'b1;              // in IDLE: must be ignored
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0 || cycle_count !== 16'd5) begin
         errors++; $display("FAIL abort: busy=%b done=%b to=%b cnt=%0d want 0 0 0 5", busy, done, timeout, cycle_count);
      end
      tick();
      abort = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || cycle_count !== 16'd5) begin errors++; $display("FAIL abort_idle: busy=%b cnt=%0d want 0 5", busy, cycle_count); end
      cpu_halt = 1'b1;
      tick();
      tick();
      pulses = 0;
      go = 1'b1;
      tick();
      go = 1'b0;
      for (int j = 1; j <= 3; j++) begin
         #1;
         if (cpu_start === 1'b1) pulses++;
         if (j == 2) begin
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL stale_halt_run: busy=%b want 1", busy); end
         end
         if (j < 3) tick();
      end
      checks++;
      if (pulses != 1) begin errors++; $display("FAIL stale_start_pulses: got %0d want 1", pulses); end
      checks++;
      if (done !== 1'b1 || cycle_count !== 16'd1) begin errors++; $display("FAIL stale_done: done=%b cnt=%0d want 1 1", done, cycle_count); end
      cpu_halt = 1'b0;
      tick();
   endtask

   task automatic test_async_reset_rerun();
      host_write(8'd5, 8'h77);
      go = 1'b1;
      tick();
      go = 1'b0;
      tick(); tick(); tick();    // now in RUN cycle 3
      cpu_mem_we = 1'b1; cpu_mem_addr = 8'd5; cpu_mem_wdata = 8'hAA;
      #1;
      checks++;
      if (mem_we !== 1'b1 || cycle_count !== 16'd2) begin errors++; $display("FAIL pre_reset: we=%b cnt=%0d want 1 2", mem_we, cycle_count); end
      #1 reset = 1'b1;
      host_req = 1'b1;
      #1;
      checks++;
      if ({busy, cpu_start, done, timeout, mem_we} !== 5'b00000 || cycle_count !== 16'd0 || host_gnt !== 1'b1) begin
         errors++; $display("FAIL async_reset: busy=%b start=%b done=%b to=%b we=%b cnt=%0d gnt=%b want 0 0 0 0 0 0 1",
                            busy, cpu_start, done, timeout, mem_we, cycle_count, host_gnt);
      end
      #1 reset = 1'b0;
      host_req = 1'b0; cpu_mem_we = 1'b0;
      tick();
      host_read(8'd5, 8'h77);
      // go together with a host write: the write still lands on the go edge.
      go = 1'b1;
      host_req = 1'b1; host_we = 1'b1; host_addr = 8'd6; host_wdata = 8'h5A;
      #1;
      checks++;
      if (host_gnt !== 1'b1) begin errors++; $display("FAIL go_same_cycle_gnt: got %b want 1", host_gnt); end
      tick();
      go = 1'b0; host_req = 1'b0; host_we = 1'b0;
      for (int j = 1; j <= 4; j++) begin
         cpu_halt = (j == 4);
         tick();
      end
      cpu_halt = 1'b0;
      #1;
      checks++;
      if (done !== 1'b1 || cycle_count !== 16'd3) begin errors++; $display("FAIL rerun_done: done=%b cnt=%0d want 1 3", done, cycle_count); end
      host_read(8'd6, 8'h5A);
   endtask

   initial begin
      test_reset();
      test_load_run();
      test_timeout();
      test_final_halt();
      test_abort_stale_halt();
      test_async_reset_rerun();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller sitting between the host/testbench side and the CPU top level. It owns the single-port data memory and hands it to the host, for loading operands and reading results, or to the CPU while a program runs. It sequences each run: issues the one-cycle `start` pulse, watches `done`/halt, counts run cycles and aborts runaway programs with a timeout.

## Interface
- `AW`, 8, data memory address width
- `DW`, 8, data memory data width
- `CNT_W`, 16, width of the run-cycle counter
- `MAX_CYCLES`, 4096, RUN cycles allowed before timeout; legal range 2..2^CNT_W-1

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `go`  in  1  host request to start a run (sampled level)
- `abort`  in  1  host request to cancel a run in progress
- `host_req`  in  1  host memory access request
- `host_we`  in  1  host write enable (qualified by `host_req`)
- `host_addr`  in  AW  host address
- `host_wdata`  in  DW  host write data
- `host_gnt`  out  1  host access performed this cycle
- `host_rdata`  out  DW  read data to host
- `cpu_start`  out  1  one-cycle start pulse to CPU
- `cpu_halt`  in  1  CPU done/halt indication (level)
- `cpu_mem_we`, `cpu_mem_addr`, `cpu_mem_wdata`  in  1/AW/DW  CPU memory port
- `cpu_mem_rdata`  out  DW  read data to CPU
- `mem_we`, `mem_addr`, `mem_wdata`  out  1/AW/DW  to data memory
- `mem_rdata`  in  DW  data memory read data, combinational
- `busy`  out  1  high in START or RUN
- `done`  out  1  last run ended by `cpu_halt`
- `timeout`  out  1  last run ended by cycle limit
- `cycle_count`  out  CNT_W  RUN cycles of current/last run

## Operation
- States: IDLE, START, RUN, DONE, TIMEOUT. Reset → IDLE.
- IDLE, DONE or TIMEOUT with `go` → START. `done`, `timeout` and `cycle_count` are cleared on that edge.
- START lasts exactly one cycle. `cpu_start`=1 and `cpu_halt` is ignored. Next state is RUN.
- RUN: `cycle_count` increments every cycle.
  - `cpu_halt`=1 → DONE, with `done` set.
  - Otherwise, if `cycle_count`==MAX_CYCLES-1 → TIMEOUT, with `timeout` set.
  - Otherwise, if `abort` → IDLE, with `done`/`timeout` left at 0.
  - Priority: halt > timeout > abort.
- `go` is ignored in START and RUN. `abort` is ignored outside RUN.
- Memory ownership:
  - Host owns memory in IDLE/DONE/TIMEOUT: `host_gnt`=`host_req`, `mem_we`=`host_req & host_we`, `mem_addr`=`host_addr`, `mem_wdata`=`host_wdata`.
  - CPU owns memory in START/RUN: `host_gnt`=0. `mem_addr`/`mem_wdata` come from the CPU port. `mem_we`=`cpu_mem_we` in RUN and 0 in START.
- `host_rdata` and `cpu_mem_rdata` both equal `mem_rdata`. They are valid only for the current owner.
- An ungranted host access is not queued. The host must hold `host_req` until `host_gnt`.
- `busy`, `cpu_start`, `host_gnt` and the memory mux are decoded combinationally from the state register. `done`, `timeout` and `cycle_count` are registered.

## Timing
- Reset values: state IDLE, `cpu_start`=0, `busy`=0, `done`=0, `timeout`=0, `cycle_count`=0. `host_gnt` follows `host_req` immediately after reset.
- Reset asserted mid-run:
  - Immediate return to IDLE and all outputs take their reset values.
  - Any CPU write in that cycle is dropped, because `mem_we` falls asynchronously.
- `go` sampled at edge N:
  - START in cycle N+1, with `cpu_start` high.
  - RUN from N+2.
  - Host loses its grant from N+1.
- Host access in the same cycle as `go` (IDLE): still granted and written at edge N.
- Halt seen in RUN cycle k (k=1 for the first RUN cycle): `done`=1 and `cycle_count`=k in the next cycle, and the host is re-granted there.
- Run with no halt: TIMEOUT after exactly MAX_CYCLES RUN cycles, with `cycle_count`=MAX_CYCLES.
- Halt in the final allowed cycle: DONE, not TIMEOUT, with `cycle_count`=MAX_CYCLES.
- `cycle_count` never wraps, because the limit is below 2^CNT_W.
- A halt level held over from the previous run does not end the new run, because START ignores it. With the level still high, RUN ends in its first cycle with k=1.
- Abort: reaches IDLE on the next edge. `cycle_count` keeps the partial count.

## Test plan
- Load, run and read back:
  - Stimulus: host writes 0x34@0 and 0x12@1, then `go`. A CPU model copies them to @2/@3 and raises halt in RUN cycle 10.
  - Required: `done`=1, `cycle_count`=10, host reads 0x34@2 and 0x12@3.
- Host request during RUN:
  - Stimulus: `host_req`/`host_we` to addr 0 with 0xFF.
  - Required: `host_gnt`=0 throughout, `mem_we` follows the CPU only, and addr 0 still reads 0x34 after DONE.
- Timeout:
  - Stimulus: MAX_CYCLES=16, halt never asserted.
  - Required: `timeout`=1, `done`=0, `cycle_count`=16, `busy` drops 18 cycles after the `go` edge.
- Halt in the final cycle:
  - Stimulus: MAX_CYCLES=16, halt in RUN cycle 16.
  - Required: DONE with `cycle_count`=16 and `timeout`=0.
- Abort and stale halt:
  - Abort in RUN cycle 5 → IDLE, `cycle_count`=5, `done`=0.
  - Halt held high from the previous run, then `go` → `cpu_start` pulses once, DONE with `cycle_count`=1.
- Async reset and re-run:
  - Stimulus: `reset` mid-RUN between clock edges.
  - Required: outputs go to reset values before the next edge.
  - Then `go` with halt in RUN cycle 3 → `done`=1, `cycle_count`=3.
